// File: rtl/trajectory_pkg.sv
`default_nettype none
// ============================================================================
// Module   : trajectory_pkg
// Purpose  : Shared widths, sentinel value and FSM encoding for the
//            trajectory RAM write path.
// Revision : 1.0 - initial release
// ============================================================================
package trajectory_pkg;

  localparam int NUM_REQ   = 4;
  localparam int DATA_W    = 19;
  localparam int ADDR_W    = 9;
  localparam int SEG_W     = 7;
  localparam int SEG_DEPTH = 1 << SEG_W;
  localparam int CNT_W     = SEG_W + 1;
  localparam int IDX_W     = $clog2(NUM_REQ);

  // Off-screen location; the draw side skips any entry holding it.
  localparam logic [DATA_W-1:0] NULL_LOC  = 19'h7FFFF;
  localparam logic [ADDR_W-1:0] FILL_LAST = ADDR_W'(NUM_REQ * SEG_DEPTH - 1);

  typedef enum logic [0:0] {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Round-robin one-hot arbiter; the pointer moves past the winner
//            only when the grant is consumed.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter
  import trajectory_pkg::*;
(
  input  logic               clock,
  input  logic               resetn,
  input  logic [NUM_REQ-1:0] request,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  logic [IDX_W-1:0] r_rr_ptr;
  logic [IDX_W-1:0] w_probe;
  logic             w_found;

  always_comb begin
    grant     = '0;
    grant_idx = r_rr_ptr;
    w_found   = 1'b0;
    w_probe   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_probe = IDX_W'((int'(r_rr_ptr) + k) % NUM_REQ);
      if (!w_found && request[w_probe]) begin
        w_found        = 1'b1;
        grant[w_probe] = 1'b1;
        grant_idx      = w_probe;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_rr_ptr <= '0;
    end else if (advance) begin
      r_rr_ptr <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/trajectory_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : trajectory_write_arbiter
// Purpose  : Shares the trajectory RAM write port between the generators,
//            sentinel-fills the RAM and tracks per-segment occupancy.
// Revision : 1.0 - initial release
// ============================================================================
module trajectory_write_arbiter
  import trajectory_pkg::*;
(
  input  logic                      clock,
  input  logic                      resetn,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_clear,
  input  logic                      fill_start,
  output logic                      busy,
  output logic [DATA_W-1:0]         mem_data,
  output logic [ADDR_W-1:0]         mem_wraddress,
  output logic                      mem_wren,
  output logic [NUM_REQ*CNT_W-1:0]  seg_count,
  output logic [NUM_REQ-1:0]        seg_wrapped
);

  state_t                     r_state;
  state_t                     w_state_next;
  logic [ADDR_W-1:0]          r_fill_addr;
  logic                       w_run;
  logic                       w_fill_done;
  logic                       w_xfer;
  logic [NUM_REQ-1:0]         w_cand;
  logic [NUM_REQ-1:0]         w_grant;
  logic [IDX_W-1:0]           w_gnt_idx;
  logic [NUM_REQ*SEG_W-1:0]   w_ptr_all;
  logic [SEG_W-1:0]           w_sel_ptr;
  logic [DATA_W-1:0]          w_sel_data;

  // A pending fill_start suppresses grants so the restart edge carries no write.
  assign w_run       = (r_state == RUN) && !fill_start;
  assign w_fill_done = (r_state == FILL) && !fill_start && (r_fill_addr == FILL_LAST);
  assign w_cand      = w_run ? (req_valid & ~req_clear) : '0;

  rr_arbiter u_rr_arbiter (
    .clock     (clock),
    .resetn    (resetn),
    .request   (w_cand),
    .advance   (w_xfer),
    .grant     (w_grant),
    .grant_idx (w_gnt_idx)
  );

  assign w_xfer     = |w_grant;
  assign req_ready  = w_grant;
  assign busy       = (r_state == FILL);
  assign w_sel_ptr  = w_ptr_all[w_gnt_idx*SEG_W +: SEG_W];
  assign w_sel_data = req_data[w_gnt_idx*DATA_W +: DATA_W];

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= FILL;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      FILL:    if (w_fill_done) w_state_next = RUN;
      RUN:     if (fill_start)  w_state_next = FILL;
      default: w_state_next = FILL;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_fill_addr <= '0;
    end else if (r_state == RUN || fill_start) begin
      r_fill_addr <= '0;
    end else begin
      r_fill_addr <= r_fill_addr + ADDR_W'(1);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      mem_wren      <= 1'b0;
      mem_wraddress <= '0;
      mem_data      <= '0;
    end else if (r_state == FILL) begin
      mem_wren <= !fill_start;
      if (!fill_start) begin
        mem_wraddress <= r_fill_addr;
        mem_data      <= NULL_LOC;
      end
    end else if (w_xfer) begin
      mem_wren      <= 1'b1;
      mem_wraddress <= {w_gnt_idx, w_sel_ptr};
      mem_data      <= w_sel_data;
    end else begin
      mem_wren <= 1'b0;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_seg
      logic [SEG_W-1:0] r_wr_ptr;
      logic [CNT_W-1:0] r_cnt;
      logic             r_wrapped;

      always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
          r_wr_ptr  <= '0;
          r_cnt     <= '0;
          r_wrapped <= 1'b0;
        end else if (w_fill_done || (w_run && req_clear[gi])) begin
          r_wr_ptr  <= '0;
          r_cnt     <= '0;
          r_wrapped <= 1'b0;
        end else if (w_grant[gi]) begin
          r_wr_ptr <= r_wr_ptr + SEG_W'(1);
          // A write into a full segment overwrites the oldest sample.
          if (r_cnt == CNT_W'(SEG_DEPTH)) begin
            r_wrapped <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
      end

      assign w_ptr_all[gi*SEG_W +: SEG_W] = r_wr_ptr;
      assign seg_count[gi*CNT_W +: CNT_W] = r_cnt;
      assign seg_wrapped[gi]              = r_wrapped;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_trajectory_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_trajectory_write_arbiter
// Purpose  : Directed self-checking bench for trajectory_write_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_trajectory_write_arbiter;
  import trajectory_pkg::*;

  logic                      clock = 1'b0;
  logic                      resetn;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        req_clear;
  logic                      fill_start;
  logic                      busy;
  logic [DATA_W-1:0]         mem_data;
  logic [ADDR_W-1:0]         mem_wraddress;
  logic                      mem_wren;
  logic [NUM_REQ*CNT_W-1:0]  seg_count;
  logic [NUM_REQ-1:0]        seg_wrapped;

  int n_checks = 0;
  int n_fail   = 0;

  trajectory_write_arbiter dut (
    .clock         (clock),
    .resetn        (resetn),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .req_clear     (req_clear),
    .fill_start    (fill_start),
    .busy          (busy),
    .mem_data      (mem_data),
    .mem_wraddress (mem_wraddress),
    .mem_wren      (mem_wren),
    .seg_count     (seg_count),
    .seg_wrapped   (seg_wrapped)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] cnt(input int i);
    return 32'(seg_count[i*CNT_W +: CNT_W]);
  endfunction

  task automatic set_data(input int i, input int v);
    req_data[i*DATA_W +: DATA_W] = DATA_W'(v);
  endtask

  task automatic check_wr(input string tag, input int addr, input int data);
    check_eq({tag, "_wren"}, 32'(mem_wren), 32'd1);
    check_eq({tag, "_addr"}, 32'(mem_wraddress), 32'(addr));
    check_eq({tag, "_data"}, 32'(mem_data), 32'(data));
  endtask

  task automatic run_fill(input string tag);
    int errs;
    int rdy;
    errs = 0;
    rdy  = 0;
    for (int a = 0; a < 512; a++) begin
      tick;
      if (mem_wren !== 1'b1 || mem_wraddress !== ADDR_W'(a) || mem_data !== NULL_LOC) errs++;
      if (a < 511 && busy !== 1'b1) errs++;
      if (a < 511 && req_ready !== '0) rdy++;
    end
    check_eq({tag, "_fill_seq_errs"}, 32'(errs), 32'd0);
    check_eq({tag, "_ready_in_fill"}, 32'(rdy), 32'd0);
    check_eq({tag, "_busy_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int errs;
    int ord;
    resetn     = 1'b0;
    req_valid  = '0;
    req_data   = '0;
    req_clear  = '0;
    fill_start = 1'b0;

    // Reset state.
    tick;
    tick;
    check_eq("rst_wren", 32'(mem_wren), 32'd0);
    check_eq("rst_addr", 32'(mem_wraddress), 32'd0);
    check_eq("rst_data", 32'(mem_data), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd1);
    check_eq("rst_count", 32'(seg_count), 32'd0);
    check_eq("rst_wrapped", 32'(seg_wrapped), 32'd0);

    // Sentinel fill after reset, with every requester knocking.
    req_valid = 4'hF;
    resetn    = 1'b1;
    run_fill("t1");
    req_valid = '0;

    // Requester 2 streams three samples.
    req_valid = 4'b0100;
    for (int n = 0; n < 3; n++) begin
      set_data(2, 100 + n);
      #1;
      check_eq("t2_ready", 32'(req_ready), 32'h4);
      tick;
      check_wr("t2_wr", 256 + n, 100 + n);
    end
    req_valid = '0;
    check_eq("t2_count2", cnt(2), 32'd3);
    tick;
    check_eq("t2_idle_wren", 32'(mem_wren), 32'd0);

    // One requester-3 write moves the pointer back to 0, then clear 2 and 3.
    req_valid = 4'b1000;
    set_data(3, 'h333);
    tick;
    check_wr("t2b_wr3", 384, 'h333);
    check_eq("t2b_count3", cnt(3), 32'd1);
    req_valid = '0;
    req_clear = 4'b1100;
    tick;
    req_clear = '0;
    check_eq("t2b_clr_wren", 32'(mem_wren), 32'd0);
    check_eq("t2b_clr_count2", cnt(2), 32'd0);
    check_eq("t2b_clr_count3", cnt(3), 32'd0);

    // All four continuously valid: strict rotation.
    for (int i = 0; i < NUM_REQ; i++) set_data(i, 1000 + i);
    req_valid = 4'hF;
    for (int c = 0; c < 8; c++) begin
      ord = c % 4;
      #1;
      check_eq("t3_ready", 32'(req_ready), 32'(1 << ord));
      tick;
      check_wr("t3_wr", ord * 128 + c / 4, 1000 + ord);
    end
    req_valid = '0;
    check_eq("t3_count0", cnt(0), 32'd2);
    check_eq("t3_count3", cnt(3), 32'd2);

    // Requester 1 overruns its segment.
    req_clear = 4'hF;
    tick;
    req_clear = '0;
    req_valid = 4'b0010;
    errs = 0;
    for (int n = 1; n <= 130; n++) begin
      set_data(1, n);
      tick;
      if (mem_wren !== 1'b1 || mem_wraddress !== ADDR_W'(128 + (n - 1) % 128) ||
          mem_data !== DATA_W'(n)) errs++;
      if (cnt(1) !== 32'((n > 128) ? 128 : n)) errs++;
      if (seg_wrapped[1] !== (n >= 129)) errs++;
      if (n == 128) begin
        check_eq("t4_count_128", cnt(1), 32'd128);
        check_eq("t4_wrap_128", 32'(seg_wrapped[1]), 32'd0);
      end
      if (n == 129) begin
        check_eq("t4_addr_129", 32'(mem_wraddress), 32'd128);
        check_eq("t4_wrap_129", 32'(seg_wrapped[1]), 32'd1);
      end
      if (n == 130) begin
        check_eq("t4_addr_130", 32'(mem_wraddress), 32'd129);
        check_eq("t4_count_130", cnt(1), 32'd128);
      end
    end
    req_valid = '0;
    check_eq("t4_loop_errs", 32'(errs), 32'd0);

    // req_clear on the requester the pointer favours.
    req_valid = 4'b0001;
    set_data(0, 7);
    tick;
    check_wr("t5_pre0", 0, 7);
    req_valid = 4'b1000;
    set_data(3, 8);
    tick;
    check_wr("t5_pre3", 384, 8);
    check_eq("t5_count0_pre", cnt(0), 32'd1);
    req_valid = 4'b0011;
    req_clear = 4'b0001;
    set_data(1, 9);
    #1;
    check_eq("t5_ready", 32'(req_ready), 32'h2);
    tick;
    check_wr("t5_wr1", 130, 9);
    check_eq("t5_count0_clr", cnt(0), 32'd0);
    req_clear = '0;
    req_valid = 4'b0001;
    set_data(0, 10);
    tick;
    check_wr("t5_wr0", 0, 10);
    check_eq("t5_count0_post", cnt(0), 32'd1);

    // fill_start mid-stream.
    req_valid = 4'b0100;
    set_data(2, 55);
    tick;
    check_wr("t6_pending", 256, 55);
    fill_start = 1'b1;
    #1;
    check_eq("t6_ready_fs", 32'(req_ready), 32'd0);
    tick;
    fill_start = 1'b0;
    check_eq("t6_wren_fs", 32'(mem_wren), 32'd0);
    check_eq("t6_busy_fs", 32'(busy), 32'd1);
    run_fill("t6");
    req_valid = '0;
    check_eq("t6_counts", 32'(seg_count), 32'd0);
    check_eq("t6_wrapped", 32'(seg_wrapped), 32'd0);

    // Asynchronous reset mid-run.
    req_valid = 4'b0001;
    set_data(0, 9);
    tick;
    check_wr("t7_wr", 0, 9);
    #2;
    resetn = 1'b0;
    #1;
    check_eq("t7_async_wren", 32'(mem_wren), 32'd0);
    check_eq("t7_async_busy", 32'(busy), 32'd1);
    check_eq("t7_async_count0", cnt(0), 32'd0);
    req_valid = '0;
    tick;
    resetn = 1'b1;
    tick;
    check_wr("t7_refill", 0, 32'h7FFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/trajectory_write_arbiter.md
# trajectory_write_arbiter

Shares the single write port of the trajectory RAM between NUM_REQ missile trajectory generators. Each generator owns a fixed 128-entry ring segment and streams 19-bit pixel locations through a valid/ready handshake. The block fills the whole RAM with an off-screen sentinel after reset or on command, then grants requesters round-robin at one write per cycle. It also publishes per-segment occupancy to the draw side.

## Interface
- NUM_REQ, 4, number of requesters; fixed at 4 so that NUM_REQ*SEG_DEPTH = 512
- DATA_W, 19, pixel memloc width (640x480 linear address)
- ADDR_W, 9, RAM write address width
- SEG_W, 7, segment offset width (SEG_DEPTH = 128)

- clock  in  1  sole clock; RAM write clock
- resetn  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  requester i has a sample
- req_data  in  NUM_REQ*DATA_W  sample of requester i at bits [i*DATA_W +: DATA_W]
- req_ready  out  NUM_REQ  combinational one-hot grant; a transfer occurs when valid and ready are both high
- req_clear  in  NUM_REQ  one-cycle pulse that empties segment i
- fill_start  in  1  pulse that restarts the sentinel fill
- busy  out  1  high while in FILL
- mem_data  out  DATA_W  registered write data
- mem_wraddress  out  ADDR_W  registered write address
- mem_wren  out  1  registered write enable
- seg_count  out  NUM_REQ*(SEG_W+1)  valid entries per segment, range 0..128
- seg_wrapped  out  NUM_REQ  sticky; segment i has overwritten old data

## Operation
- FSM states: FILL and RUN. Reset enters FILL with fill_addr = 0.
- FILL:
  - Each cycle writes NULL_LOC (19'h7FFFF) to fill_addr, then increments fill_addr.
  - After address 511 is written: go to RUN; all write pointers, seg_count and seg_wrapped are zero.
  - req_ready stays 0 throughout.
- RUN:
  - Candidates are requesters with req_valid=1 and req_clear=0.
  - The winner is the first candidate at or after rr_ptr, wrapping.
  - req_ready is asserted for the winner only.
  - On a transfer:
    - mem_wraddress <= {i[1:0], wr_ptr[i]} and mem_data <= sample.
    - wr_ptr[i] increments mod 128.
    - seg_count[i] increments and saturates at 128.
    - rr_ptr <= (i+1) mod NUM_REQ.
  - With no transfer, mem_wren <= 0 and rr_ptr holds.
- Write wrap:
  - A write at wr_ptr = 127 wraps the pointer to 0.
  - The first write made while seg_count = 128 sets seg_wrapped[i].
- req_clear[i] in RUN:
  - At the next edge, wr_ptr[i], seg_count[i] and seg_wrapped[i] become 0.
  - Requester i is not granted that cycle.
  - The RAM contents are not touched.
- req_clear during FILL is ignored; the end of the fill already clears every segment.
- fill_start:
  - In RUN: no grants that cycle. At the next edge the state becomes FILL with fill_addr = 0.
  - In FILL: restarts the fill at address 0.
  - fill_start takes priority over req_clear.
- Reset values: mem_wren=0, mem_wraddress=0, mem_data=0, seg_count=0, seg_wrapped=0, busy=1, rr_ptr=0.

## Timing
- A transfer at edge k puts mem_wren/addr/data valid in cycle k..k+1. The RAM samples them at edge k+1, so write latency is 1 cycle.
- seg_count and wr_ptr update at edge k, the same edge as the transfer.
- The fill takes 512 cycles; busy falls at the edge that writes address 511. The first grant is possible in the following cycle.
- Throughput is 1 write per cycle aggregate.
- A continuously valid requester is granted at least once every NUM_REQ cycles.
- A write registered before fill_start still completes; fill address 0 is written one cycle after the fill_start edge.
- Asynchronous reset mid-fill or mid-run immediately drops mem_wren and restarts the fill once resetn deasserts.

## Structure
- trajectory_pkg holds:
  - DATA_W, ADDR_W, SEG_W, NUM_REQ
  - NULL_LOC = 19'h7FFFF
  - the FSM state encoding {FILL, RUN}
- Sub-module rr_arbiter:
  - Inputs: clock, resetn, request vector, advance.
  - Outputs: one-hot grant and grant index.
  - Owns rr_ptr.
- The top level holds the FSM, fill counter, per-segment pointers/counters and the output registers.

## Test plan
- Reset release → 512 consecutive writes at addresses 0..511, all with data 19'h7FFFF; busy drops after address 511; no req_ready high during the fill.
- Requester 2 streams 3 samples (100, 101, 102) → writes at addresses 256, 257, 258; seg_count[2] = 3.
- All four requesters valid continuously for 8 cycles → grant order 0,1,2,3,0,1,2,3; addresses 0,128,256,384,1,129,257,385.
- Requester 1 sends 130 samples → seg_count[1] saturates at 128; seg_wrapped[1] rises on the 129th write at address 128; the 130th write goes to address 129.
- req_clear[0] while req_valid[0]=1 and rr_ptr=0 → requester 1 is granted instead; next cycle seg_count[0]=0 and the following write of requester 0 goes to address 0.
- fill_start mid-stream → the pending write completes; address 0 receives NULL_LOC one cycle later; all seg_count are 0 after the fill.
